lcd_command_sequencer: RTL and testbench

Sequences the Spartan-3E character LCD (50 MHz) from power-up to ready, then accepts user commands/characters and issues them one at a time to the 4-bit instruction FSM.
- During power-on init, it drives the single-nibble wake-up writes directly.
- It then drives the configuration instructions and user requests through the instruction FSM's next_instruction/busy handshake.
- Top level muxes LCD_E/SF_D between this block (init_active=1) and the instruction FSM (init_active=0).

---
 rtl/lcd_pkg.sv | 65 ++++++
 rtl/lcd_delay_timer.sv | 44 ++++
 rtl/lcd_command_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_command_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared constants, state encoding and helpers for the
//                Spartan-3E character LCD command sequencer and the 4-bit
//                instruction FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Instruction words: [9]=RS, [8]=RW, [7:0]=instruction byte
    localparam logic [9:0] FUNCTION_SET       = 10'h028;
    localparam logic [9:0] ENTRY_MODE_SET     = 10'h006;
    localparam logic [9:0] DISPLAY_ON_OFF     = 10'h00C;
    localparam logic [9:0] CLEAR_DISPLAY      = 10'h001;
    localparam logic [9:0] RETURN_CURSOR_HOME = 10'h002;

    // Default timing counts at 50 MHz, shared with the instruction FSM
    localparam int T_PWRON_DEF = 750000;
    localparam int T_GAP1_DEF  = 205000;
    localparam int T_GAP2_DEF  = 5000;
    localparam int T_GAP3_DEF  = 2000;
    localparam int T_SETUP_DEF = 2;
    localparam int T_EHIGH_DEF = 12;
    localparam int T_CLEAR_DEF = 82000;
    localparam int CNT_W_DEF   = 20;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_PWR_WAIT  = 4'd0,
        ST_NIB_SETUP = 4'd1,
        ST_NIB_E     = 4'd2,
        ST_NIB_HOLD  = 4'd3,
        ST_NIB_GAP   = 4'd4,
        ST_ISSUE     = 4'd5,
        ST_ACK       = 4'd6,
        ST_BUSY      = 4'd7,
        ST_POST      = 4'd8,
        ST_READY     = 4'd9
    } seq_state_e;

    // Configuration instruction issued after the wake-up nibbles
    function automatic logic [9:0] cfg_word(input logic [1:0] idx);
        logic [9:0] w;
        case (idx)
            2'd0:    w = FUNCTION_SET;
            2'd1:    w = ENTRY_MODE_SET;
            2'd2:    w = DISPLAY_ON_OFF;
            default: w = CLEAR_DISPLAY;
        endcase
        return w;
    endfunction

    // Wake-up nibble sequence 0x3, 0x3, 0x3, 0x2
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Clear and home instructions need a long settle time afterwards
    function automatic logic needs_clear_wait(input logic [9:0] w);
        return (w[9:2] == 8'd0) && (w[1:0] != 2'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_delay_timer
//  Description : Clearable up-counter with a terminal-count flag. The count
//                saturates at the limit so a phase of length T ends when the
//                count reaches T-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_delay_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart on clear, otherwise advance until the limit
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (!done_o) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/lcd_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_command_sequencer
//  Description : Brings the Spartan-3E character LCD from power-up to ready
//                (wake-up nibbles driven directly, configuration words via
//                the instruction FSM), then forwards user commands one at a
//                time through the next_instruction/busy handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_command_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRON = T_PWRON_DEF,
    parameter int T_GAP1  = T_GAP1_DEF,
    parameter int T_GAP2  = T_GAP2_DEF,
    parameter int T_GAP3  = T_GAP3_DEF,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EHIGH = T_EHIGH_DEF,
    parameter int T_CLEAR = T_CLEAR_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    input  logic [9:0] cmd_db_i,
    output logic       cmd_ready_o,
    output logic       init_done_o,
    output logic       next_instruction_o,
    output logic [9:0] db_o,
    input  logic       instr_busy_i,
    output logic       init_active_o,
    output logic [3:0] init_sf_d_o,
    output logic       init_lcd_e_o
);

    // Terminal counts: a phase of T cycles ends when the count equals T-1
    localparam logic [CNT_W-1:0] LIM_PWRON = CNT_W'(T_PWRON - 1);
    localparam logic [CNT_W-1:0] LIM_GAP1  = CNT_W'(T_GAP1 - 1);
    localparam logic [CNT_W-1:0] LIM_GAP2  = CNT_W'(T_GAP2 - 1);
    localparam logic [CNT_W-1:0] LIM_GAP3  = CNT_W'(T_GAP3 - 1);
    localparam logic [CNT_W-1:0] LIM_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LIM_EHIGH = CNT_W'(T_EHIGH - 1);
    localparam logic [CNT_W-1:0] LIM_CLEAR = CNT_W'(T_CLEAR - 1);

    seq_state_e state_q, state_d;
    logic [1:0] nib_idx_q, nib_idx_d;
    logic [1:0] cfg_idx_q, cfg_idx_d;
    logic [9:0] db_q, db_d;
    logic       init_done_q, init_done_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       next_instr_q, next_instr_d;
    logic       init_active_q, init_active_d;
    logic [3:0] sf_nib_q, sf_nib_d;
    logic       lcd_e_q, lcd_e_d;

    logic             tmr_clr;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_limit;

    // Every state change restarts the phase timer
    assign tmr_clr = (state_d != state_q);

    lcd_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (tmr_clr),
        .limit_i (tmr_limit),
        .done_o  (tmr_done)
    );

    // Phase length for the current state; untimed states saturate harmlessly
    always_comb begin
        tmr_limit = '1;
        case (state_q)
            ST_PWR_WAIT:  tmr_limit = LIM_PWRON;
            ST_NIB_SETUP: tmr_limit = LIM_SETUP;
            ST_NIB_E:     tmr_limit = LIM_EHIGH;
            ST_NIB_GAP: begin
                case (nib_idx_q)
                    2'd0:    tmr_limit = LIM_GAP1;
                    2'd1:    tmr_limit = LIM_GAP2;
                    default: tmr_limit = LIM_GAP3;
                endcase
            end
            ST_POST:      tmr_limit = LIM_CLEAR;
            default:      tmr_limit = '1;
        endcase
    end

    // Next-state, sequence indices and instruction word
    always_comb begin
        state_d     = state_q;
        nib_idx_d   = nib_idx_q;
        cfg_idx_d   = cfg_idx_q;
        db_d        = db_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (tmr_done) state_d = ST_NIB_SETUP;
            end
            ST_NIB_SETUP: begin
                if (tmr_done) state_d = ST_NIB_E;
            end
            ST_NIB_E: begin
                if (tmr_done) state_d = ST_NIB_HOLD;
            end
            ST_NIB_HOLD: begin
                state_d = ST_NIB_GAP;
            end
            ST_NIB_GAP: begin
                if (tmr_done) begin
                    if (nib_idx_q == 2'd3) begin
                        cfg_idx_d = 2'd0;
                        db_d      = cfg_word(2'd0);
                        state_d   = ST_ISSUE;
                    end else begin
                        nib_idx_d = nib_idx_q + 2'd1;
                        state_d   = ST_NIB_SETUP;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (instr_busy_i) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (!instr_busy_i) state_d = ST_POST;
            end
            ST_POST: begin
                // Clear/home hold here for the full settle time; others pass through
                if (!needs_clear_wait(db_q) || tmr_done) begin
                    if (init_done_q) begin
                        state_d = ST_READY;
                    end else if (cfg_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = ST_READY;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                        db_d      = cfg_word(cfg_idx_q + 2'd1);
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_READY: begin
                if (cmd_valid_i) begin
                    db_d    = cmd_db_i;
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase
    end

    // Output values decoded from the upcoming state so they change on the same edge
    always_comb begin
        cmd_ready_d   = (state_d == ST_READY);
        next_instr_d  = (state_d == ST_ISSUE);
        lcd_e_d       = (state_d == ST_NIB_E);
        init_active_d = init_active_q && (state_d != ST_ISSUE);
        sf_nib_d      = 4'h0;
        if (state_d inside {ST_NIB_SETUP, ST_NIB_E, ST_NIB_HOLD, ST_NIB_GAP}) begin
            sf_nib_d = init_nibble(nib_idx_d);
        end
    end

    // State, index and output registers; reset aborts and restarts the sequence
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_PWR_WAIT;
            nib_idx_q     <= 2'd0;
            cfg_idx_q     <= 2'd0;
            db_q          <= 10'd0;
            init_done_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            next_instr_q  <= 1'b0;
            init_active_q <= 1'b1;
            sf_nib_q      <= 4'h0;
            lcd_e_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            nib_idx_q     <= nib_idx_d;
            cfg_idx_q     <= cfg_idx_d;
            db_q          <= db_d;
            init_done_q   <= init_done_d;
            cmd_ready_q   <= cmd_ready_d;
            next_instr_q  <= next_instr_d;
            init_active_q <= init_active_d;
            sf_nib_q      <= sf_nib_d;
            lcd_e_q       <= lcd_e_d;
        end
    end

    assign cmd_ready_o        = cmd_ready_q;
    assign init_done_o        = init_done_q;
    assign next_instruction_o = next_instr_q;
    assign db_o               = db_q;
    assign init_active_o      = init_active_q;
    assign init_sf_d_o        = sf_nib_q;
    assign init_lcd_e_o       = lcd_e_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_command_sequencer
//  Description : Scoreboard bench for lcd_command_sequencer with shortened
//                timing, a behavioural instruction-FSM busy responder and
//                randomized user commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_command_sequencer;

    localparam int P_PWRON = 40;
    localparam int P_GAP1  = 30;
    localparam int P_GAP2  = 20;
    localparam int P_GAP3  = 10;
    localparam int P_SETUP = 2;
    localparam int P_EHIGH = 12;
    localparam int P_CLEAR = 50;
    localparam int BUDGET  = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_db = 10'd0;
    logic       busy = 1'b0;
    logic       cmd_ready, init_done, next_instruction, init_active, init_lcd_e;
    logic [9:0] db;
    logic [3:0] init_sf_d;

    lcd_command_sequencer #(
        .T_PWRON (P_PWRON), .T_GAP1 (P_GAP1), .T_GAP2 (P_GAP2), .T_GAP3 (P_GAP3),
        .T_SETUP (P_SETUP), .T_EHIGH (P_EHIGH), .T_CLEAR (P_CLEAR), .CNT_W (20)
    ) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_db_i           (cmd_db),
        .cmd_ready_o        (cmd_ready),
        .init_done_o        (init_done),
        .next_instruction_o (next_instruction),
        .db_o               (db),
        .instr_busy_i       (busy),
        .init_active_o      (init_active),
        .init_sf_d_o        (init_sf_d),
        .init_lcd_e_o       (init_lcd_e)
    );

    always #5 clk = ~clk;

    // Edge counter: sampled at a negedge it holds the number of the last posedge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules
    logic [9:0] cfg_words [4] = '{10'h028, 10'h006, 10'h00C, 10'h001};

    function automatic int post_len(input logic [9:0] w);
        if (w == 10'h001 || w == 10'h002 || w == 10'h003) return P_CLEAR;
        return 1;
    endfunction

    function automatic int gap_len(input int k);
        if (k == 0) return P_GAP1;
        if (k == 1) return P_GAP2;
        return P_GAP3;
    endfunction

    // Instruction FSM responder: busy rises 2 cycles after the pulse, random length
    int bm_wait = 0, bm_hold = 0, fall_cyc = 0, acc_cyc = 0;
    always @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            bm_wait <= 0;
            bm_hold <= 0;
        end else begin
            if (bm_wait == 1) begin
                busy    <= 1'b1;
                bm_hold <= $urandom_range(1, 25);
            end else if (busy) begin
                if (bm_hold <= 1) begin
                    busy     <= 1'b0;
                    fall_cyc <= cyc + 1;
                end else begin
                    bm_hold <= bm_hold - 1;
                end
            end
            bm_wait <= next_instruction ? 1 : 0;
            if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
        end
    end

    // Scoreboard state
    logic [9:0] cmd_q [$];
    int         e_cyc_q [$];
    int         e_nib_q [$];
    int         e_rise_cyc = 0, first_pulse = 0, cfg_cnt = 0, bad = 0;
    logic [9:0] cur_word = 10'd0;
    logic [9:0] exp_w;
    logic       tracking = 1'b0;
    logic       pv_e = 1'b0, pv_ni = 1'b0, pv_busy = 1'b0, pv_rdy = 1'b0;
    logic       pv_done = 1'b0, pv_rst = 1'b1;

    // Monitor: arms the init schedule at reset release, checks every DUT event
    always @(negedge clk) begin
        if (pv_rst && !rst) begin
            int t;
            t = cyc - 1 + P_PWRON + P_SETUP;
            e_cyc_q.delete();
            e_nib_q.delete();
            for (int k = 0; k < 4; k++) begin
                e_cyc_q.push_back(t);
                e_nib_q.push_back((k == 3) ? 2 : 3);
                t = t + P_EHIGH + 1 + gap_len(k) + ((k < 3) ? P_SETUP : 0);
            end
            first_pulse = t;
            cfg_cnt     = 0;
            tracking    = 1'b0;
        end
        if (!rst) begin
            if (init_lcd_e && !pv_e) begin
                if (e_cyc_q.size() == 0) begin
                    chk("e_unexpected", 1, 0);
                end else begin
                    chk("e_rise_cycle", cyc, e_cyc_q.pop_front());
                    chk("e_nibble", init_sf_d, e_nib_q.pop_front());
                    e_rise_cyc = cyc;
                end
            end
            if (!init_lcd_e && pv_e) chk("e_width", cyc - e_rise_cyc, P_EHIGH);

            if (tracking) begin
                if (db !== cur_word) bad++;
                if (pv_busy && !busy) begin
                    chk("db_stable", bad, 0);
                    tracking = 1'b0;
                end
            end

            if (next_instruction) begin
                chk("pulse_single", pv_ni, 0);
                exp_w = cur_word;
                if (cfg_cnt < 4) begin
                    exp_w = cfg_words[cfg_cnt];
                    chk("cfg_pulse_cycle", cyc,
                        (cfg_cnt == 0) ? first_pulse : fall_cyc + 1 + post_len(cur_word));
                    chk("cfg_db", db, exp_w);
                    chk("cfg_init_done_low", init_done, 0);
                    if (cfg_cnt == 0) begin
                        chk("init_active_off", init_active, 0);
                        chk("init_sf_d_zero", init_sf_d, 0);
                    end
                    cfg_cnt++;
                end else if (cmd_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    exp_w = cmd_q.pop_front();
                    chk("cmd_pulse_cycle", cyc, acc_cyc);
                    chk("cmd_db", db, exp_w);
                    chk("cmd_after_init", init_done, 1);
                end
                cur_word = exp_w;
                tracking = 1'b1;
                bad      = 0;
            end

            if (cmd_ready && !pv_rdy) begin
                chk("ready_cycle", cyc, fall_cyc + 1 + post_len(cur_word));
                chk("ready_init_done", init_done, 1);
                chk("ready_after_cfg", cfg_cnt, 4);
            end
            if (init_done && !pv_done) chk("done_with_ready", cmd_ready, 1);
        end
        pv_e    = init_lcd_e;
        pv_ni   = next_instruction;
        pv_busy = busy;
        pv_rdy  = cmd_ready;
        pv_done = init_done;
        pv_rst  = rst;
    end

    task automatic send(input logic [9:0] w, input int extra);
        int n;
        @(negedge clk);
        cmd_db    = w;
        cmd_valid = 1'b1;
        cmd_q.push_back(w);
        n = 0;
        while (!cmd_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        else repeat (1 + extra) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_next_instr"}, next_instruction, 0);
        chk({tag, "_db"}, db, 0);
        chk({tag, "_init_active"}, init_active, 1);
        chk({tag, "_init_sf_d"}, init_sf_d, 0);
        chk({tag, "_init_lcd_e"}, init_lcd_e, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        #2 rst = 1'b0;
        @(negedge clk);
        chk("pwr_idle_active", init_active, 1);
        chk("pwr_idle_e", init_lcd_e, 0);

        // Request issued during init must wait for init_done
        send(10'h248, 0);
        wait_ready();
        send(10'h241, 2);
        wait_ready();
        send(10'h002, 0);
        wait_ready();
        send(10'h010, 1);
        wait_ready();
        for (int i = 0; i < 8; i++) begin
            send(10'($urandom_range(0, 1023)), $urandom_range(0, 3));
            wait_ready();
        end

        // Reset in the middle of a clear settle wait
        send(10'h001, 0);
        n = 0;
        while (!busy && n < BUDGET) begin @(negedge clk); n++; end
        while (busy && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) chk("clear_busy_timeout", 0, 1);
        repeat (10) @(negedge clk);
        chk("mid_clear_not_ready", cmd_ready, 0);
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        repeat (3) @(negedge clk);
        cmd_q.delete();
        #2 rst = 1'b0;
        @(negedge clk);
        chk("restart_idle_active", init_active, 1);

        send(10'h241, 3);
        wait_ready();
        repeat (5) @(negedge clk);
        chk("e_events_left", e_cyc_q.size(), 0);
        chk("cmd_left", cmd_q.size(), 0);
        chk("cfg_count", cfg_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
